hilo_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for the HI/LO multiply/divide resource of the execute stage.

---
 rtl/hilo_muldiv_ctrl_if.sv | 26 ++
 rtl/hilo_muldiv_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO multiply/divide unit connection.
// The pipeline side drives the instruction, and the unit returns HI/LO, busy, done and stall.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       aluop;
  logic             valid;
  logic             flush;
  logic [WIDTH-1:0] rA;
  logic [WIDTH-1:0] rB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output aluop, valid, flush, rA, rB,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  aluop, valid, flush, rA, rB,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative unsigned multiply/divide sequencer that owns the architectural HI/LO registers.
// It retires one bit per cycle and stalls the execute stage while an operation is in flight.
module hilo_muldiv_ctrl #(
  parameter int         WIDTH   = 32,
  parameter logic [5:0] MULT_OP = 6'b000010,
  parameter logic [5:0] DIV_OP  = 6'b000011,
  parameter logic [5:0] MFHI_OP = 6'b000100,
  parameter logic [5:0] MFLO_OP = 6'b000101
) (
  input logic               clock,
  input logic               reset,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t               r_state, w_state_nx;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nx;
  logic [WIDTH-1:0]     r_mcand, w_mcand_nx;
  logic [WIDTH-1:0]     r_rem, w_rem_nx;
  logic [WIDTH-1:0]     r_quot, w_quot_nx;
  logic [WIDTH-1:0]     r_divisor, w_divisor_nx;
  logic [WIDTH-1:0]     r_hi, w_hi_nx;
  logic [WIDTH-1:0]     r_lo, w_lo_nx;
  logic                 r_done, w_done_nx;

  logic                 w_busy;
  logic                 w_start;
  logic                 w_last;
  logic                 w_uses_unit;

  // Multiply step: add the multiplicand into the upper half when the current multiplier
  // bit (acc[0]) is set, then shift the whole accumulator right by one.
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_step;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step on the WIDTH+1-bit partial remainder. When the shifted value
  // is >= the divisor, the true difference is below the divisor, so WIDTH bits hold it.
  logic [WIDTH:0]       w_div_shift;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_diff;
  logic [WIDTH-1:0]     w_rem_step;
  logic [WIDTH-1:0]     w_quot_step;

  assign w_div_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_div_ge    = w_div_shift[WIDTH] | (w_div_shift[WIDTH-1:0] >= r_divisor);
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_step  = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
  assign w_quot_step = {r_quot[WIDTH-2:0], w_div_ge};

  assign w_busy      = (r_state != IDLE);
  assign w_start     = bus.valid & ~bus.flush & (r_state == IDLE);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_uses_unit = (bus.aluop == MULT_OP) | (bus.aluop == DIV_OP)
                     | (bus.aluop == MFHI_OP) | (bus.aluop == MFLO_OP);

  always_comb begin
    // NOTE: every next-state variable gets a default up front, so no path through the case leaves one unassigned and infers a latch.
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_acc_nx     = r_acc;
    w_mcand_nx   = r_mcand;
    w_rem_nx     = r_rem;
    w_quot_nx    = r_quot;
    w_divisor_nx = r_divisor;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    w_done_nx    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_start && bus.aluop == MULT_OP) begin
          w_state_nx = MUL;
          w_cnt_nx   = '0;
          w_acc_nx   = {{WIDTH{1'b0}}, bus.rB};
          w_mcand_nx = bus.rA;
        end else if (w_start && bus.aluop == DIV_OP) begin
          if (bus.rB == '0) begin
            w_hi_nx   = bus.rA;
            w_lo_nx   = '1;
            w_done_nx = 1'b1;
          end else begin
            w_state_nx   = DIV;
            w_cnt_nx     = '0;
            w_rem_nx     = '0;
            w_quot_nx    = bus.rA;
            w_divisor_nx = bus.rB;
          end
        end
      end

      MUL: begin
        if (bus.flush) begin
          w_state_nx = IDLE;
        end else begin
          w_acc_nx = w_mul_step;
          w_cnt_nx = r_cnt + 1'b1;
          if (w_last) begin
            w_hi_nx    = w_mul_step[2*WIDTH-1:WIDTH];
            w_lo_nx    = w_mul_step[WIDTH-1:0];
            w_done_nx  = 1'b1;
            w_state_nx = IDLE;
          end
        end
      end

      DIV: begin
        if (bus.flush) begin
          w_state_nx = IDLE;
        end else begin
          w_rem_nx  = w_rem_step;
          w_quot_nx = w_quot_step;
          w_cnt_nx  = r_cnt + 1'b1;
          if (w_last) begin
            w_hi_nx    = w_rem_step;
            w_lo_nx    = w_quot_step;
            w_done_nx  = 1'b1;
            w_state_nx = IDLE;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, which keeps the update order-independent.
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_acc     <= w_acc_nx;
      r_mcand   <= w_mcand_nx;
      r_rem     <= w_rem_nx;
      r_quot    <= w_quot_nx;
      r_divisor <= w_divisor_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_done    <= w_done_nx;
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.stall = bus.valid & w_busy & w_uses_unit;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO values are queued at issue and
// compared on every done pulse. Per-scenario tasks check timing, stall and flush behaviour.
module tb_hilo_muldiv_ctrl;

  localparam int         W       = 32;
  localparam logic [5:0] MULT_OP = 6'b000010;
  localparam logic [5:0] DIV_OP  = 6'b000011;
  localparam logic [5:0] MFHI_OP = 6'b000100;
  localparam logic [5:0] MFLO_OP = 6'b000101;
  localparam logic [5:0] NOP_OP  = 6'b000000;
  localparam logic [5:0] ODD_OP  = 6'b111111;

  logic clock;
  logic reset;

  hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [2*W-1:0] sb_q[$];

  function automatic logic [2*W-1:0] model(input logic [5:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    if (op == MULT_OP) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p;
    end
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  // The scoreboard pops one expectation per done pulse.
  always @(negedge clock) begin
    logic [2*W-1:0] exp_v;
    if (!reset && bus.done === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_done: got hi=%h lo=%h, required no done pulse", bus.hi, bus.lo);
      end else begin
        exp_v = sb_q.pop_front();
        if ({bus.hi, bus.lo} !== exp_v)begin
          n_err++;
          $display("FAIL sb_result: got hi=%h lo=%h, required hi=%h lo=%h",
                   bus.hi, bus.lo, exp_v[2*W-1:W], exp_v[W-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.aluop = NOP_OP;
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    bus.rA    = '0;
    bus.rB    = '0;
  endtask

  // Present one instruction for a single cycle; it returns #1 after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit track);
    if (track) sb_q.push_back(model(op, a, b));
    bus.aluop = op;
    bus.valid = 1'b1;
    bus.rA    = a;
    bus.rB    = b;
    @(posedge clock); #1;
    bus.valid = 1'b0;
    bus.aluop = NOP_OP;
  endtask

  // This helper counts the edges after acceptance until done is seen; the count is -1 if it times out.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.valid = 1'b1;
    bus.aluop = MFHI_OP;
    #1;
    n_cmp++; if (bus.hi !== '0)    begin n_err++; $display("FAIL reset_hi: got %h required 0", bus.hi); end
    n_cmp++; if (bus.lo !== '0)    begin n_err++; $display("FAIL reset_lo: got %h required 0", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b required 0", bus.stall); end
    drive_idle();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mult_basic();
    bit early;
    issue(MULT_OP, 32'd7, 32'd6, 1'b1);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_after_accept: got %b required 1", bus.busy); end
    early = 1'b0;
    for (int k = 1; k < W; k++) begin
      @(posedge clock); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.hi !== '0 || bus.lo !== '0) early = 1'b1;
    end
    n_cmp++; if (early) begin n_err++; $display("FAIL mult_no_early_change: got early done/busy drop/HI-LO change, required none before E32"); end
    @(posedge clock); #1;
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL mult_done_at_e32: got %b required 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_clear: got %b required 0", bus.busy); end
    n_cmp++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin n_err++; $display("FAIL mult_7x6: got hi=%h lo=%h required hi=0 lo=2a", bus.hi, bus.lo); end
    @(posedge clock); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b required 0", bus.done); end
  endtask

  task automatic test_mult_wide();
    int lat;
    issue(MULT_OP, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat != W) begin n_err++; $display("FAIL mult_wide_latency: got %0d required %0d", lat, W); end
    n_cmp++; if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_wide: got hi=%h lo=%h required hi=1 lo=fffffffe", bus.hi, bus.lo); end
  endtask

  task automatic test_div();
    int lat;
    issue(DIV_OP, 32'd100, 32'd7, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat != W) begin n_err++; $display("FAIL div_latency: got %0d required %0d", lat, W); end
    n_cmp++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_err++; $display("FAIL div_100_7: got hi=%h lo=%h required hi=2 lo=e", bus.hi, bus.lo); end
    @(posedge clock); #1;
    issue(DIV_OP, 32'd100, 32'd0, 1'b1);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL div0_done_next_cycle: got %b required 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL div0_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd100) begin n_err++; $display("FAIL div0_result: got hi=%h lo=%h required hi=64 lo=ffffffff", bus.hi, bus.lo); end
    @(posedge clock); #1;
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL div0_after: got done=%b busy=%b required 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_mflo_stall();
    logic [2*W-1:0] exp_v;
    bit bad;
    int n;
    exp_v = model(MULT_OP, 32'h0001_E240, 32'd789);
    issue(MULT_OP, 32'h0001_E240, 32'd789, 1'b1);
    bus.valid = 1'b1;
    bus.aluop = ODD_OP;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_other_op: got %b required 0", bus.stall); end
    bus.valid = 1'b0;
    bus.aluop = NOP_OP;
    repeat (5) @(posedge clock);
    #1;
    bus.valid = 1'b1;
    bus.aluop = MFLO_OP;
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL stall_mflo_busy: got %b required 1", bus.stall); end
    bad = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (bus.done !== 1'b1 && bus.stall !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad || bus.done !== 1'b1) begin n_err++; $display("FAIL stall_held: got stall drop or no done (done=%b), required stall until done", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b required 0", bus.stall); end
    n_cmp++; if (bus.lo !== exp_v[W-1:0]) begin n_err++; $display("FAIL mflo_value: got %h required %h", bus.lo, exp_v[W-1:0]); end
    drive_idle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(MULT_OP, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    sb_q.delete();
    n_cmp++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h required 0/0", bus.hi, bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL reset_mid_flags: got busy=%b done=%b required 0/0", bus.busy, bus.done); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    issue(DIV_OP, 32'd1000, 32'd33, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat != W) begin n_err++; $display("FAIL reset_recover_latency: got %0d required %0d", lat, W); end
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    logic [2*W-1:0] keep;
    keep = model(MULT_OP, 32'h1234, 32'h10);
    issue(MULT_OP, 32'h1234, 32'h10, 1'b1);
    wait_done(lat);
    @(posedge clock); #1;
    issue(DIV_OP, 32'd555, 32'd5, 1'b0);
    repeat (19) @(posedge clock);
    #1;
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL flush_abort: got busy=%b done=%b required 0/0", bus.busy, bus.done); end
    n_cmp++; if ({bus.hi, bus.lo} !== keep) begin n_err++; $display("FAIL flush_hilo_kept: got %h required %h", {bus.hi, bus.lo}, keep); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL flush_no_done: got done pulse, required none"); end
    bus.flush = 1'b1;
    issue(MULT_OP, 32'd3, 32'd3, 1'b0);
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_blocks_start: got busy=%b required 0", bus.busy); end
    issue(DIV_OP, 32'd555, 32'd5, 1'b1);
    wait_done(lat);
    n_cmp++; if (lat != W) begin n_err++; $display("FAIL flush_recover_latency: got %0d required %0d", lat, W); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [5:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? MULT_OP : DIV_OP;
      a  = $urandom;
      b  = (i == 3) ? '0 : ((i == 5) ? W'($urandom_range(1, 255)) : W'($urandom));
      issue(op, a, b, 1'b1);
      wait_done(lat);
      n_cmp++;
      if (lat != ((op == DIV_OP && b == '0) ? 0 : W)) begin
        n_err++;
        $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, lat, (op == DIV_OP && b == '0) ? 0 : W);
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_mult_basic();
    test_mult_wide();
    test_div();
    test_mflo_stall();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    repeat (3) @(posedge clock);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: got %0d pending results, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
